// File: rtl/step_size_scheduler.sv
// Adaptive-equalizer step-size scheduler: phase FSM (idle/CMA/LMS) that loads mu per phase.
// Optional halving decay toward mu_floor is built only when STEP_DECAY_EN is defined.
module step_size_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  adaptation_phase,
  input  logic        freeze,
  input  logic [15:0] mu_cma_init,
  input  logic [15:0] mu_lms_init,
  input  logic [15:0] mu_floor,
  input  logic [31:0] decay_period,
  output logic [15:0] mu,
  output logic        update_en,
  output logic        phase_change,
  output logic [7:0]  decay_count,
  output logic        phase_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMA, S_LMS} state_t;

  state_t      state, state_next;
  logic        legal_move, illegal_move;
  logic        active, load_en, update_en_next;
  logic [15:0] load_mu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= S_IDLE;
    else if (enable) state <= state_next;
  end

  // Only forward moves are legal; anything else keeps the state and flags an error.
  always_comb begin
    state_next   = state;
    legal_move   = 1'b0;
    illegal_move = 1'b0;
    if (adaptation_phase > 3'd2) begin
      illegal_move = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (adaptation_phase == 3'd1) begin
            state_next = S_CMA;
            legal_move = 1'b1;
          end else if (adaptation_phase == 3'd2) begin
            state_next = S_LMS;
            legal_move = 1'b1;
          end
        end
        S_CMA: begin
          if (adaptation_phase == 3'd2) begin
            state_next = S_LMS;
            legal_move = 1'b1;
          end else if (adaptation_phase == 3'd0) begin
            illegal_move = 1'b1;
          end
        end
        S_LMS: begin
          if (adaptation_phase != 3'd2) illegal_move = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    active         = (state == S_CMA) || (state == S_LMS);
    load_en        = enable && legal_move;
    load_mu        = (state_next == S_CMA) ? mu_cma_init : mu_lms_init;
    update_en_next = enable && !freeze && active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_en    <= 1'b0;
      phase_change <= 1'b0;
      phase_err    <= 1'b0;
    end else begin
      update_en    <= update_en_next;
      phase_change <= load_en;
      if (enable && illegal_move) phase_err <= 1'b1;
    end
  end

`ifdef STEP_DECAY_EN
  logic [31:0] period_cnt;
  logic        terminal;
  logic [15:0] mu_half;

  assign terminal = (decay_period != 32'd0) && (period_cnt == decay_period - 32'd1);
  assign mu_half  = mu >> 1;

  // A phase load takes priority over a coincident decay terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mu          <= 16'd0;
      period_cnt  <= 32'd0;
      decay_count <= 8'd0;
    end else if (load_en) begin
      mu          <= load_mu;
      period_cnt  <= 32'd0;
      decay_count <= 8'd0;
    end else if (enable && !freeze && active) begin
      if (terminal) begin
        period_cnt <= 32'd0;
        if (mu > mu_floor) begin
          mu <= (mu_half > mu_floor) ? mu_half : mu_floor;
          if (decay_count != 8'hFF) decay_count <= decay_count + 8'd1;
        end
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_decay_cfg;
  assign unused_decay_cfg = ^{decay_period, mu_floor};
  assign decay_count      = 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mu <= 16'd0;
    else if (load_en) mu <= load_mu;
  end
`endif

endmodule

// File: tb/tb_step_size_scheduler.sv
// Directed bench for step_size_scheduler: stimulus pushes expected outputs into a scoreboard queue,
// a negedge monitor pops and compares. Expected decay values depend on STEP_DECAY_EN.
module tb_step_size_scheduler;

`ifdef STEP_DECAY_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  adaptation_phase = 3'd0;
  logic        freeze = 1'b0;
  logic [15:0] mu_cma_init = 16'h4000;
  logic [15:0] mu_lms_init = 16'h1000;
  logic [15:0] mu_floor = 16'h0800;
  logic [31:0] decay_period = 32'd4;
  logic [15:0] mu;
  logic        update_en;
  logic        phase_change;
  logic [7:0]  decay_count;
  logic        phase_err;

  typedef struct {
    string       name;
    logic [15:0] mu;
    logic        ue;
    logic        pc;
    logic [7:0]  dc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  step_size_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .adaptation_phase(adaptation_phase),
    .freeze(freeze), .mu_cma_init(mu_cma_init), .mu_lms_init(mu_lms_init),
    .mu_floor(mu_floor), .decay_period(decay_period), .mu(mu), .update_en(update_en),
    .phase_change(phase_change), .decay_count(decay_count), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] emu, input logic eue,
                             input logic epc, input logic [7:0] edc, input logic eerr);
    checks++;
    if (mu !== emu || update_en !== eue || phase_change !== epc ||
        decay_count !== edc || phase_err !== eerr) begin
      failures++;
      $display("[TB] FAIL %s: got mu=%h ue=%b pc=%b dc=%0d err=%b, expected mu=%h ue=%b pc=%b dc=%0d err=%b",
               name, mu, update_en, phase_change, decay_count, phase_err, emu, eue, epc, edc, eerr);
    end
  endtask

  // One clock edge of stimulus; the expectation describes outputs after that edge.
  task automatic applyStimulus(input string name, input logic en, input logic [2:0] ph,
                               input logic frz, input logic [15:0] emu, input logic eue,
                               input logic epc, input logic [7:0] edc, input logic eerr);
    exp_t e;
    enable           = en;
    adaptation_phase = ph;
    freeze           = frz;
    @(posedge clk);
    e.name = name; e.mu = emu; e.ue = eue; e.pc = epc; e.dc = edc; e.err = eerr;
    sb.push_back(e);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.name, e.mu, e.ue, e.pc, e.dc, e.err);
    end
  end

  function automatic logic [15:0] cmaMu(input int k);
    if (!DEC)    return 16'h4000;
    if (k < 4)   return 16'h4000;
    if (k < 8)   return 16'h2000;
    if (k < 12)  return 16'h1000;
    return 16'h0800;
  endfunction

  function automatic logic [7:0] cmaDc(input int k);
    if (!DEC)   return 8'd0;
    if (k < 4)  return 8'd0;
    if (k < 8)  return 8'd1;
    if (k < 12) return 8'd2;
    return 8'd3;
  endfunction

  initial begin
    logic [15:0] lmsMu;
    logic [7:0]  lmsDc;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_state", 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus("idle_phase0", 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);

    applyStimulus("enter_cma", 1'b1, 3'd1, 1'b0, 16'h4000, 1'b0, 1'b1, 8'd0, 1'b0);
    for (int k = 1; k <= 20; k++)
      applyStimulus("cma_decay", 1'b1, 3'd1, 1'b0, cmaMu(k), 1'b1, 1'b0, cmaDc(k), 1'b0);
    for (int k = 21; k <= 23; k++)
      applyStimulus("cma_pre_terminal", 1'b1, 3'd1, 1'b0, cmaMu(k), 1'b1, 1'b0, cmaDc(k), 1'b0);

    applyStimulus("cma_to_lms_on_terminal", 1'b1, 3'd2, 1'b0, 16'h1000, 1'b1, 1'b1, 8'd0, 1'b0);
    repeat (2)
      applyStimulus("lms_run", 1'b1, 3'd2, 1'b0, 16'h1000, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (6)
      applyStimulus("lms_freeze", 1'b1, 3'd2, 1'b1, 16'h1000, 1'b0, 1'b0, 8'd0, 1'b0);
    applyStimulus("lms_unfreeze", 1'b1, 3'd2, 1'b0, 16'h1000, 1'b1, 1'b0, 8'd0, 1'b0);

    lmsMu = DEC ? 16'h0800 : 16'h1000;
    lmsDc = DEC ? 8'd1 : 8'd0;
    applyStimulus("lms_decay_after_freeze", 1'b1, 3'd2, 1'b0, lmsMu, 1'b1, 1'b0, lmsDc, 1'b0);
    applyStimulus("lms_at_floor", 1'b1, 3'd2, 1'b0, lmsMu, 1'b1, 1'b0, lmsDc, 1'b0);
    applyStimulus("enable_low", 1'b0, 3'd1, 1'b0, lmsMu, 1'b0, 1'b0, lmsDc, 1'b0);
    applyStimulus("enable_back", 1'b1, 3'd2, 1'b0, lmsMu, 1'b1, 1'b0, lmsDc, 1'b0);
    applyStimulus("lms_to_cma_illegal", 1'b1, 3'd1, 1'b0, lmsMu, 1'b1, 1'b0, lmsDc, 1'b1);
    applyStimulus("illegal_code5", 1'b1, 3'd5, 1'b0, lmsMu, 1'b1, 1'b0, lmsDc, 1'b1);
    repeat (3)
      applyStimulus("err_sticky", 1'b1, 3'd2, 1'b0, lmsMu, 1'b1, 1'b0, lmsDc, 1'b1);

    @(negedge clk);
    #1 rst = 1'b1;
    #1 checkOutput("async_reset", 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;

    repeat (2)
      applyStimulus("post_reset_idle", 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0);
    applyStimulus("idle_to_lms", 1'b1, 3'd2, 1'b0, 16'h1000, 1'b0, 1'b1, 8'd0, 1'b0);
    applyStimulus("lms_update_en", 1'b1, 3'd2, 1'b0, 16'h1000, 1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus("lms_to_idle_illegal", 1'b1, 3'd0, 1'b0, 16'h1000, 1'b1, 1'b0, 8'd0, 1'b1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_size_scheduler.md
STEP_SIZE_SCHEDULER -- requirements
Module: step_size_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 enable  in  1  sample strobe; all state advances only when 1.
REQ-005 adaptation_phase  in  3  phase code from adaptation controller: 0 startup, 1 CMA, 2 LMS; 3..7 illegal.
REQ-006 freeze  in  1  holds mu and decay timing; suppresses update_en.
REQ-007 mu_cma_init  in  16  unsigned Q0.16 initial step size for CMA.
REQ-008 mu_lms_init  in  16  unsigned Q0.16 initial step size for LMS.
REQ-009 mu_floor  in  16  unsigned Q0.16 minimum step size reached by decay.
REQ-010 decay_period  in  32  enabled, unfrozen cycles between halvings; 0 disables decay.
REQ-011 mu  out  16  current step size to the tap-update datapath.
REQ-012 update_en  out  1  tap-update permission, registered.
REQ-013 phase_change  out  1  one-cycle pulse on a legal phase transition.
REQ-014 decay_count  out  8  number of halvings applied in the current phase, saturating at 255.
REQ-015 phase_err  out  1  sticky flag for an illegal phase code or an illegal transition.

Function
REQ-016 The FSM SHALL have states S_IDLE, S_CMA and S_LMS; the state register updates only on edges where enable=1.
REQ-017 The legal transitions SHALL be S_IDLE->S_CMA on phase 1, S_CMA->S_LMS on phase 2, and S_IDLE->S_LMS on phase 2.
REQ-018 On the edge that makes a legal transition, the block SHALL register phase_change=1 for exactly one cycle.
REQ-019 Entering S_CMA SHALL load mu=mu_cma_init, clear the period counter and clear decay_count on the same edge.
REQ-020 Entering S_LMS SHALL load mu=mu_lms_init, clear the period counter and clear decay_count on the same edge.
REQ-021 Phase codes 3..7, S_LMS->S_CMA/S_IDLE and S_CMA->S_IDLE SHALL leave the state unchanged and set phase_err until reset.
REQ-022 In S_IDLE, mu SHALL be 0 and update_en SHALL be 0.
REQ-023 The period counter (32 bit) SHALL increment on edges where enable=1, freeze=0 and state is S_CMA or S_LMS.
REQ-024 When the period counter equals decay_period-1 with decay_period!=0, the block SHALL clear the counter and apply one decay step.
REQ-025 Decay step: if mu<=mu_floor, mu holds and decay_count is unchanged.
REQ-026 Decay step otherwise: mu <= max(mu>>1, mu_floor), and decay_count increments, saturating at 255.
REQ-027 When a phase load and a decay step fall on the same edge, the phase load SHALL win and no decay SHALL be applied.
REQ-028 freeze=1 SHALL hold mu, the period counter and decay_count, while phase transitions are still honoured.
REQ-029 update_en SHALL be registered as enable & ~freeze & (state is S_CMA or S_LMS), giving one cycle of latency.
REQ-030 When enable=0, every register SHALL hold its value; phase_change and update_en SHALL be 0 on the following cycle.
REQ-031 mu SHALL never wrap; all arithmetic SHALL be unsigned with no overflow paths.

Reset
REQ-032 While rst=1, state SHALL be S_IDLE and mu, period counter, decay_count, update_en, phase_change and phase_err SHALL all be 0.
REQ-033 A reset asserted mid-phase SHALL take effect immediately and asynchronously, and after release the block SHALL restart from S_IDLE.

Configuration
REQ-034 With macro STEP_DECAY_EN defined, REQ-023..REQ-027 SHALL be implemented.
REQ-035 Without STEP_DECAY_EN, mu SHALL equal the phase initial value for the whole phase, decay_count SHALL be constant 0, decay_period SHALL be ignored, and the period counter SHALL be absent.

Verification
REQ-036 Reset, enable=1, phase 0 for 10 cycles -> mu=0, update_en=0, phase_err=0.
REQ-037 mu_cma_init=0x4000, phase 0->1 -> phase_change is a 1-cycle pulse, mu=0x4000 next cycle, update_en=1 one cycle later.
REQ-038 STEP_DECAY_EN, decay_period=4, mu_floor=0x0800, CMA from 0x4000 -> mu steps 0x2000, 0x1000, 0x0800 every 4 cycles, then holds; decay_count ends at 3.
REQ-039 Phase 1->2 on the same edge as a decay terminal, mu_lms_init=0x1000 -> mu=0x1000, decay_count=0, phase_change=1.
REQ-040 In S_LMS drive phase=1, then phase=5 -> state stays S_LMS, phase_err=1 and stays sticky until rst.
REQ-041 freeze=1 for 6 cycles mid-CMA with decay_period=4 -> mu constant, update_en=0; decay resumes with the counter value held during the freeze.
